exec_unit: RTL and testbench

Execute stage of the pipelined processor. Consumes operands held in the decode/execute pipeline register and produces the ALU result. Single-cycle ALU ops complete combinationally. MULT/MULTU/DIV/DIVU run on an iterative 32-step engine that writes the HI/LO registers and asserts `busy` to freeze the upstream pipeline registers until the result is committed.

---
 rtl/exec_pkg.sv | 26 ++
 rtl/exec_if.sv | 27 ++
 rtl/exec_muldiv_seq.sv | 137 +++++++++++++
 rtl/exec_unit.sv | 57 +++++
 tb/tb_exec_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: op codes, mul/div FSM states, datapath width.
package exec_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/exec_if.sv
// Decode/execute pipeline register contents and execute-stage results.
interface exec_if #(parameter int WIDTH = exec_pkg::WIDTH);

    logic             en;
    logic             start;
    logic [3:0]       ALUControlE;
    logic             ALUSrcE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] SignImm;
    logic [WIDTH-1:0] ALUOutE;
    logic             ZeroE;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output en, start, ALUControlE, ALUSrcE, SrcAE, SrcBE, SignImm,
        input  ALUOutE, ZeroE, busy, hi, lo
    );

    modport slave (
        input  en, start, ALUControlE, ALUSrcE, SrcAE, SrcBE, SignImm,
        output ALUOutE, ZeroE, busy, hi, lo
    );

endinterface

// File: rtl/exec_muldiv_seq.sv
// Iterative multiply/divide engine: one bit per cycle on magnitudes, sign fixup at the end,
// result committed to HI/LO.
module muldiv_seq
    import exec_pkg::*;
#(
    parameter int WIDTH = exec_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q;      // {remainder, quotient} or running {product_hi, product_lo/multiplier}
    logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic               neg_a_q;
    logic               neg_b_q;
    logic               div0_q;
    logic [WIDTH-1:0]   a_raw_q;

    logic               is_signed;
    logic               is_div;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign sa        = is_signed & a[WIDTH-1];
    assign sb        = is_signed & b[WIDTH-1];
    assign a_mag     = sa ? -a : a;
    assign b_mag     = sb ? -b : b;

    assign busy = (state_q == IDLE && start && is_muldiv(op)) ||
                  (state_q == MUL) || (state_q == DIV);

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_top;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring step: shift the next dividend bit into the remainder, keep the
        // subtraction only if it did not go negative.
        div_top  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, opnd_q};
        div_ok   = !div_diff[WIDTH];
        div_next = {(div_ok ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], div_ok};

        prod   = (neg_a_q ^ neg_b_q) ? -mul_next : mul_next;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (state_q == DIV) begin
            if (div0_q) begin
                fix_lo = '1;
                fix_hi = a_raw_q;
            end else begin
                fix_lo = (neg_a_q ^ neg_b_q) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
                fix_hi = neg_a_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
            end
        end
    end

    // NOTE: every register here, HI/LO included, is cleared by the synchronous reset so a
    // reset mid-operation discards the partial result; all updates use non-blocking <=.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            div0_q  <= 1'b0;
            a_raw_q <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && is_muldiv(op)) begin
                        count_q <= CW'(WIDTH - 1);
                        neg_a_q <= sa;
                        neg_b_q <= sb;
                        div0_q  <= is_div && (b == '0);
                        a_raw_q <= a;
                        if (is_div) begin
                            acc_q   <= {{WIDTH{1'b0}}, a_mag};
                            opnd_q  <= b_mag;
                            state_q <= DIV;
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, b_mag};
                            opnd_q  <= a_mag;
                            state_q <= MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_q <= (state_q == DIV) ? div_next : mul_next;
                    if (count_q == '0) begin
                        hi      <= fix_hi;
                        lo      <= fix_lo;
                        state_q <= DONE;
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                DONE: begin
                    if (en) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: combinational ALU and operand-B mux, with the iterative mul/div engine
// providing HI/LO and the stall request.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = exec_pkg::WIDTH
) (
    input  logic   clk,
    input  logic   rst_n,
    exec_if.slave  bus
);

    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic             md_busy;

    assign src_b = bus.ALUSrcE ? bus.SignImm : bus.SrcBE;

    // Mul/div always takes SrcBE regardless of ALUSrcE.
    muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .start (bus.start),
        .op    (bus.ALUControlE),
        .a     (bus.SrcAE),
        .b     (bus.SrcBE),
        .busy  (md_busy),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    always_comb begin
        alu_y = '0;
        case (bus.ALUControlE)
            OP_AND:  alu_y = bus.SrcAE & src_b;
            OP_OR:   alu_y = bus.SrcAE | src_b;
            OP_ADD:  alu_y = bus.SrcAE + src_b;
            OP_XOR:  alu_y = bus.SrcAE ^ src_b;
            OP_SUB:  alu_y = bus.SrcAE - src_b;
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(bus.SrcAE) < $signed(src_b)};
            OP_NOR:  alu_y = ~(bus.SrcAE | src_b);
            OP_MFHI: alu_y = md_hi;
            OP_MFLO: alu_y = md_lo;
            default: alu_y = '0;
        endcase
    end

    assign bus.ALUOutE = alu_y;
    assign bus.ZeroE   = (alu_y == '0);
    assign bus.busy    = md_busy;
    assign bus.hi      = md_hi;
    assign bus.lo      = md_lo;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU vectors, mul/div results and latency, reset and DONE hold.
module tb_exec_unit;
    import exec_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    exec_if u_if ();

    exec_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] y;
        logic        z;
    } vec_t;

    vec_t vecs [11];

    // Issues a mul/div (SignImm set to junk with ALUSrcE=1 to prove SrcBE is used) and
    // returns the number of cycles busy was high. Leaves the unit in DONE with en=1.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        u_if.en          = 1'b1;
        u_if.start       = 1'b1;
        u_if.ALUControlE = op;
        u_if.ALUSrcE     = 1'b1;
        u_if.SrcAE       = a;
        u_if.SrcBE       = b;
        u_if.SignImm     = 32'hDEAD_BEEF;
        cycles = 0;
        #1;
        while (u_if.busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic retire_md();
        @(posedge clk); #1;
        u_if.start       = 1'b0;
        u_if.ALUControlE = OP_AND;
        #1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        u_if.en          = 1'b1;
        u_if.start       = 1'b0;
        u_if.ALUControlE = OP_AND;
        u_if.ALUSrcE     = 1'b0;
        u_if.SrcAE       = '0;
        u_if.SrcBE       = '0;
        u_if.SignImm     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total_cnt++;
        if (u_if.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", u_if.busy);
        else pass_cnt++;
        total_cnt++;
        if (u_if.hi !== 32'h0 || u_if.lo !== 32'h0)
            $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", u_if.hi, u_if.lo);
        else pass_cnt++;
    endtask

    task automatic test_alu();
        vecs = '{
            '{OP_ADD,  1'b1, 32'h7FFF_FFFF, 32'h1234_5678, 32'h0000_0001, 32'h8000_0000, 1'b0},
            '{OP_SUB,  1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0009, 32'h0000_0000, 1'b1},
            '{OP_SLT,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0},
            '{OP_SLT,  1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1},
            '{OP_AND,  1'b0, 32'hF0F0_1234, 32'hFF00_FF00, 32'h0000_0000, 32'hF000_1200, 1'b0},
            '{OP_OR,   1'b0, 32'hF0F0_0000, 32'h0F00_00FF, 32'h0000_0000, 32'hFFF0_00FF, 1'b0},
            '{OP_XOR,  1'b0, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0000_0000, 32'hF00F_0FF0, 1'b0},
            '{OP_NOR,  1'b0, 32'hF0F0_0000, 32'h0F00_00FF, 32'h0000_0000, 32'h000F_FF00, 1'b0},
            '{4'b0100, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1},
            '{OP_ADD,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1},
            '{OP_SUB,  1'b1, 32'h0000_0003, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0}
        };
        for (int i = 0; i < 11; i++) begin
            u_if.start       = 1'b1;
            u_if.ALUControlE = vecs[i].op;
            u_if.ALUSrcE     = vecs[i].src;
            u_if.SrcAE       = vecs[i].a;
            u_if.SrcBE       = vecs[i].b;
            u_if.SignImm     = vecs[i].imm;
            #1;
            total_cnt++;
            if (u_if.ALUOutE !== vecs[i].y || u_if.ZeroE !== vecs[i].z || u_if.busy !== 1'b0)
                $display("FAIL alu_vec%0d: got y=%h z=%b busy=%b want y=%h z=%b busy=0",
                         i, u_if.ALUOutE, u_if.ZeroE, u_if.busy, vecs[i].y, vecs[i].z);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        u_if.start = 1'b0;
    endtask

    task automatic test_mult();
        int cyc;
        run_md(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, cyc);
        total_cnt++;
        if (cyc !== 33) $display("FAIL mult_busy_cycles: got %0d want 33", cyc);
        else pass_cnt++;
        total_cnt++;
        if (u_if.hi !== 32'hFFFF_FFFF || u_if.lo !== 32'hFFFF_FFEB)
            $display("FAIL mult_hilo: got hi=%h lo=%h want FFFFFFFF/FFFFFFEB", u_if.hi, u_if.lo);
        else pass_cnt++;
        @(posedge clk); #1;
        u_if.ALUControlE = OP_MFLO;
        u_if.ALUSrcE     = 1'b0;
        #1;
        total_cnt++;
        if (u_if.ALUOutE !== 32'hFFFF_FFEB || u_if.busy !== 1'b0)
            $display("FAIL mflo: got %h busy=%b want FFFFFFEB busy=0", u_if.ALUOutE, u_if.busy);
        else pass_cnt++;
        u_if.ALUControlE = OP_MFHI;
        #1;
        total_cnt++;
        if (u_if.ALUOutE !== 32'hFFFF_FFFF)
            $display("FAIL mfhi: got %h want FFFFFFFF", u_if.ALUOutE);
        else pass_cnt++;
        @(posedge clk); #1;
        u_if.start = 1'b0;
    endtask

    task automatic test_muldiv_results();
        int cyc;
        run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        total_cnt++;
        if (u_if.hi !== 32'hFFFF_FFFE || u_if.lo !== 32'h0000_0001)
            $display("FAIL multu_hilo: got hi=%h lo=%h want FFFFFFFE/00000001", u_if.hi, u_if.lo);
        else pass_cnt++;
        retire_md();

        run_md(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, cyc);
        total_cnt++;
        if (cyc !== 33) $display("FAIL div_busy_cycles: got %0d want 33", cyc);
        else pass_cnt++;
        total_cnt++;
        if (u_if.hi !== 32'hFFFF_FFFF || u_if.lo !== 32'hFFFF_FFFD)
            $display("FAIL div_hilo: got hi=%h lo=%h want FFFFFFFF/FFFFFFFD", u_if.hi, u_if.lo);
        else pass_cnt++;
        retire_md();

        run_md(OP_DIVU, 32'h0000_0009, 32'h0000_0000, cyc);
        total_cnt++;
        if (cyc !== 33 || u_if.hi !== 32'h0000_0009 || u_if.lo !== 32'hFFFF_FFFF)
            $display("FAIL divu_by_zero: got cyc=%0d hi=%h lo=%h want 33 00000009/FFFFFFFF",
                     cyc, u_if.hi, u_if.lo);
        else pass_cnt++;
        retire_md();

        run_md(OP_DIV, 32'hFFFF_FFFB, 32'h0000_0000, cyc);
        total_cnt++;
        if (u_if.hi !== 32'hFFFF_FFFB || u_if.lo !== 32'hFFFF_FFFF)
            $display("FAIL div_by_zero: got hi=%h lo=%h want FFFFFFFB/FFFFFFFF", u_if.hi, u_if.lo);
        else pass_cnt++;
        retire_md();

        run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        total_cnt++;
        if (u_if.hi !== 32'h0000_0000 || u_if.lo !== 32'h8000_0000)
            $display("FAIL div_overflow: got hi=%h lo=%h want 00000000/80000000", u_if.hi, u_if.lo);
        else pass_cnt++;
        retire_md();
    endtask

    task automatic test_idle_nostart();
        u_if.start       = 1'b0;
        u_if.ALUControlE = OP_MULT;
        u_if.SrcAE       = 32'h0000_0011;
        u_if.SrcBE       = 32'h0000_0022;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (u_if.busy !== 1'b0 || u_if.hi !== 32'h0 || u_if.lo !== 32'h8000_0000)
                $display("FAIL idle_nostart%0d: got busy=%b hi=%h lo=%h want 0 00000000/80000000",
                         i, u_if.busy, u_if.hi, u_if.lo);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_done_stall();
        int cyc;
        run_md(OP_MULTU, 32'h0000_0002, 32'h0000_0003, cyc);
        u_if.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (u_if.busy !== 1'b0 || u_if.hi !== 32'h0 || u_if.lo !== 32'h6)
                $display("FAIL done_hold%0d: got busy=%b hi=%h lo=%h want 0 00000000/00000006",
                         i, u_if.busy, u_if.hi, u_if.lo);
            else pass_cnt++;
        end
        u_if.en = 1'b1;
        retire_md();
        total_cnt++;
        if (u_if.busy !== 1'b0) $display("FAIL done_release: got busy=%b want 0", u_if.busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        u_if.en          = 1'b1;
        u_if.start       = 1'b1;
        u_if.ALUControlE = OP_MULT;
        u_if.ALUSrcE     = 1'b0;
        u_if.SrcAE       = 32'h0000_0005;
        u_if.SrcBE       = 32'h0000_0005;
        repeat (10) @(posedge clk);
        #1;
        total_cnt++;
        if (u_if.busy !== 1'b1) $display("FAIL midop_busy: got %b want 1", u_if.busy);
        else pass_cnt++;
        rst_n      = 1'b0;
        u_if.start = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (u_if.busy !== 1'b0 || u_if.hi !== 32'h0 || u_if.lo !== 32'h0)
            $display("FAIL midop_reset: got busy=%b hi=%h lo=%h want 0 0/0",
                     u_if.busy, u_if.hi, u_if.lo);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_md(OP_MULTU, 32'h0000_0004, 32'h0000_0005, cyc);
        total_cnt++;
        if (cyc !== 33 || u_if.lo !== 32'd20)
            $display("FAIL post_reset_mult: got cyc=%0d lo=%h want 33 00000014", cyc, u_if.lo);
        else pass_cnt++;
        retire_md();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mult();
        test_muldiv_results();
        test_idle_nostart();
        test_done_stall();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
